alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Command sequencer that sits directly upstream of the combinational 8-bit ALU. It accepts tagged ALU commands (A, B, opcode) over a valid/ready handshake and buffers them in a small FIFO. It presents each command to the ALU for one cycle, registers the ALU's Out/Carry, and returns a tagged response over a second valid/ready handshake. It converts the ALU's purely combinational behaviour into a flow-controlled, pipelined transaction stream.

## Interface
Parameters:
- DATA_W, 8, operand/result width; must match the ALU.
- TAG_W, 4, width of the command tag echoed on the response.
- DEPTH, 4, command FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept; low while rst_n low or FIFO full.
- cmd_a  in  DATA_W  operand A.
- cmd_b  in  DATA_W  operand B.
- cmd_op  in  4  opcode, type operation_e.
- cmd_tag  in  TAG_W  transaction tag.
- alu_a  out  DATA_W  to ALU A; registered.
- alu_b  out  DATA_W  to ALU B; registered.
- alu_opcode  out  4  to ALU OPCode; registered.
- alu_out  in  DATA_W  from ALU Out.
- alu_carry  in  1  from ALU Carry.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts.
- rsp_out  out  DATA_W  captured result.
- rsp_carry  out  1  captured carry.
- rsp_tag  out  TAG_W  tag of the command.
- rsp_err  out  1  error flag (see Configuration).

## Operation
- Push: cmd_valid && cmd_ready at an edge writes {a,b,op,tag} into the FIFO. No bypass: an empty FIFO still costs one cycle.
- FSM states: IDLE, ISSUE, RESP.
  - IDLE: if FIFO non-empty, pop the head into alu_a/alu_b/alu_opcode/tag register; go to ISSUE.
  - ISSUE: ALU inputs are stable for the full cycle. At the end edge, capture alu_out→rsp_out and alu_carry→rsp_carry; go to RESP.
  - RESP: rsp_valid=1. Outputs hold stable until rsp_valid && rsp_ready. On the handshake, if FIFO non-empty, pop the next command and go to ISSUE; else go to IDLE.
- alu_* registers hold their last value outside ISSUE; only ISSUE-cycle values are captured.
- Simultaneous push and pop in one cycle are both honoured; occupancy is unchanged.
- cmd_ready is combinational: rst_n && (count != DEPTH). A pop in the same cycle does not raise cmd_ready when full.
- Responses return in command order. Tags are passed through unchecked.

## Timing
- Reset (rst_n low at an edge) clears FIFO pointers/count, sets FSM to IDLE, and zeroes alu_a, alu_b, alu_opcode, rsp_valid, rsp_out, rsp_carry, rsp_tag and rsp_err.
- Reset mid-operation discards all buffered and in-flight commands. No response is emitted for them.
- Latency: command accepted at edge k into an empty, idle block → popped at k+1 → captured at k+2 → rsp_valid high in the cycle after edge k+2.
- Throughput: with rsp_ready held high and the FIFO non-empty, one response every 2 cycles (RESP→ISSUE→RESP).
- Back-pressure: with rsp_ready low, the FIFO absorbs DEPTH further commands, then cmd_ready drops.

## Configuration
- ALU_DIVZERO_CHECK_EN defined:
  - In ISSUE, if alu_opcode is Div or Mod and alu_b==0, capture rsp_out = all-ones, rsp_carry=0, rsp_err=1 instead of the ALU outputs.
  - rsp_err is 0 for all other commands.
- Undefined: rsp_err is tied 0 and ALU outputs are always captured unmodified.

## Structure
- Shared package alu_pkg:
  - operation_e, 4-bit: Add=0, Sub=1, Mul=2, Div=3, Mod=4, And=5, Or=6, NotA=7, Xor=8, BitWise_And=9, BitWise_Or=10, BitWise_NotB=11, Shift_RightA=12, Shift_LeftB=13, IncrementA=14, DecrementB=15.
  - Default DATA_W constant.
  - seq_state_e {IDLE, ISSUE, RESP}.
- Sub-module alu_cmd_fifo: parameterised width/depth synchronous FIFO with push, pop, full, empty and a count of width $clog2(DEPTH)+1.

## Test plan
- Single Add A=0xF0, B=0x20, tag=3, rsp_ready=1 → rsp_valid after edge k+2 with rsp_out=0x10, rsp_carry=1, rsp_tag=3.
- Burst of 6 commands with rsp_ready=0, DEPTH=4 → 1 command captured in RESP plus 4 in the FIFO; cmd_ready low after the 5th accept. Releasing rsp_ready yields 5 responses in order, spaced 2 cycles apart.
- Div A=0x07, B=0x00 with ALU_DIVZERO_CHECK_EN → rsp_out=0xFF, rsp_err=1. Without the macro → rsp_err=0 and rsp_out equals the ALU value.
- rsp_ready toggled randomly during IncrementA A=0xFF → rsp_out=0x00 and rsp_carry=1 held stable until the handshake.
- rst_n low for one cycle while in ISSUE with 2 commands queued → all outputs 0 next cycle, no responses emitted, cmd_ready=1 after release.

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : shared types for the ALU command sequencer.
//   ALU_DATA_W   - default operand/result width of the downstream ALU
//   operation_e  - 4-bit ALU opcode encoding
//   seq_state_e  - sequencer FSM states
//   is_div_op()  - true for opcodes that divide by operand B
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_DATA_W = 8;

  typedef enum logic [3:0] {
    Add          = 4'd0,
    Sub          = 4'd1,
    Mul          = 4'd2,
    Div          = 4'd3,
    Mod          = 4'd4,
    And          = 4'd5,
    Or           = 4'd6,
    NotA         = 4'd7,
    Xor          = 4'd8,
    BitWise_And  = 4'd9,
    BitWise_Or   = 4'd10,
    BitWise_NotB = 4'd11,
    Shift_RightA = 4'd12,
    Shift_LeftB  = 4'd13,
    IncrementA   = 4'd14,
    DecrementB   = 4'd15
  } operation_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } seq_state_e;

  function automatic logic is_div_op(input operation_e op);
    return (op == Div) || (op == Mod);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if : command, ALU and response signals of the sequencer.
//   cmd_*  : command valid/ready channel (upstream -> sequencer)
//   alu_*  : registered ALU operands out, combinational ALU result back
//   rsp_*  : response valid/ready channel (sequencer -> consumer)
// Modports:
//   slave  - the sequencer itself
//   master - the environment (command source, ALU and response sink)
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = 4
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  operation_e        cmd_op;
  logic [TAG_W-1:0]  cmd_tag;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  operation_e        alu_opcode;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_out;
  logic              rsp_carry;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_opcode,
    input  alu_out, alu_carry,
    output rsp_valid, rsp_out, rsp_carry, rsp_tag, rsp_err,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_opcode,
    output alu_out, alu_carry,
    input  rsp_valid, rsp_out, rsp_carry, rsp_tag, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/alu_op_sequencer_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo : synchronous FIFO holding packed ALU commands.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (clears pointers/count)
//   push_i      - write data_i (ignored when full)
//   pop_i       - drop the head entry (ignored when empty)
//   data_i      - entry to write
//   data_o      - current head entry (valid while !empty_o)
//   full_o      - DEPTH entries held
//   empty_o     - no entries held
//   count_o     - occupancy, 0..DEPTH
// Push and pop in the same cycle are both honoured.
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Head is read directly so the sequencer can pop and load in one edge.
  assign data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer : flow-controlled front end for a combinational 8-bit ALU.
// Commands {a, b, op, tag} are buffered in a FIFO, presented to the ALU for
// one cycle (ISSUE), the ALU result is captured at the end of that cycle and
// returned as a tagged response (RESP) that holds until accepted.
// Ports:
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset; drops all queued/in-flight work
//   bus    - alu_op_sequencer_if.slave: cmd_* in, alu_* to/from ALU, rsp_* out
// Build option:
//   ALU_DIVZERO_CHECK_EN - when defined, Div/Mod with B == 0 returns
//                          out = all-ones, carry = 0, err = 1 instead of the
//                          ALU result. Otherwise rsp_err is always 0.
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  localparam int CMD_W = 2 * DATA_W + 4 + TAG_W;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Command FIFO
  logic [CMD_W-1:0] fifo_din;
  logic [CMD_W-1:0] fifo_dout;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             unused_fifo_full;

  logic [DATA_W-1:0] head_a;
  logic [DATA_W-1:0] head_b;
  operation_e        head_op;
  logic [TAG_W-1:0]  head_tag;

  // FSM
  seq_state_e state_q;
  seq_state_e state_d;
  logic       load_cmd;
  logic       capture;

  // Datapath registers
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  operation_e        alu_opcode_q;
  logic [TAG_W-1:0]  issue_tag_q;
  logic [DATA_W-1:0] rsp_out_q;
  logic              rsp_carry_q;
  logic [TAG_W-1:0]  rsp_tag_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] cap_out;
  logic              cap_carry;
  logic              cap_err;

  // -------------------------------------------------------------------------
  // Command intake
  // -------------------------------------------------------------------------
  // Readiness comes from the occupancy only; a same-cycle pop does not open a
  // slot for a same-cycle push.
  assign bus.cmd_ready    = rst_n && (fifo_count != CNT_W'(DEPTH));
  assign fifo_push        = bus.cmd_valid && bus.cmd_ready;
  assign fifo_din         = {bus.cmd_tag, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign unused_fifo_full = fifo_full;

  assign head_a   = fifo_dout[DATA_W-1:0];
  assign head_b   = fifo_dout[2*DATA_W-1:DATA_W];
  assign head_op  = operation_e'(fifo_dout[2*DATA_W +: 4]);
  assign head_tag = fifo_dout[2*DATA_W+4 +: TAG_W];

  alu_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (fifo_din),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load_cmd = 1'b0;
    capture  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          load_cmd = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        // Chain straight into the next command to sustain one response
        // every two cycles.
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            load_cmd = 1'b1;
            state_d  = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Result capture
  // -------------------------------------------------------------------------
`ifdef ALU_DIVZERO_CHECK_EN
  logic div_by_zero;
  assign div_by_zero = is_div_op(alu_opcode_q) && (alu_b_q == '0);
  assign cap_out     = div_by_zero ? '1 : bus.alu_out;
  assign cap_carry   = div_by_zero ? 1'b0 : bus.alu_carry;
  assign cap_err     = div_by_zero;
`else
  assign cap_out     = bus.alu_out;
  assign cap_carry   = bus.alu_carry;
  assign cap_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= Add;
      issue_tag_q  <= '0;
      rsp_out_q    <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      // ALU operands only change on a pop, so they stay stable through ISSUE
      // and hold their last value otherwise.
      if (load_cmd) begin
        alu_a_q      <= head_a;
        alu_b_q      <= head_b;
        alu_opcode_q <= head_op;
        issue_tag_q  <= head_tag;
      end
      if (capture) begin
        rsp_out_q   <= cap_out;
        rsp_carry_q <= cap_carry;
        rsp_tag_q   <= issue_tag_q;
        rsp_err_q   <= cap_err;
      end
    end
  end

  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_out    = rsp_out_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer : self-checking bench for alu_op_sequencer.
// A stand-in combinational ALU drives alu_out/alu_carry. Each accepted
// command pushes its expected response into a queue; a negedge monitor
// compares every presented response against the queue head and pops on the
// handshake. Honours ALU_DIVZERO_CHECK_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_pkg::*;

  typedef struct packed {
    logic [7:0] out;
    logic       carry;
    logic [3:0] tag;
    logic       err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_rsp = 0;
  int   rise_cyc = 0;
  int   hs_cyc[$];
  rsp_t exp_q[$];
  logic sent_done;

  alu_op_sequencer_if #(.DATA_W(8), .TAG_W(4)) bus ();

  alu_op_sequencer #(.DATA_W(8), .TAG_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Stand-in ALU: {carry, out}
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input operation_e op);
    logic [15:0] p;
    logic [8:0]  r;
    p = 16'(a) * 16'(b);
    case (op)
      Add:          r = {1'b0, a} + {1'b0, b};
      Sub:          r = {(a < b), a - b};
      Mul:          r = {(p[15:8] != 8'h00), p[7:0]};
      Div:          r = {1'b0, (b == 8'h00) ? 8'h00 : a / b};
      Mod:          r = {1'b0, (b == 8'h00) ? a : a % b};
      And:          r = {8'h00, (a != 8'h00) && (b != 8'h00)};
      Or:           r = {8'h00, (a != 8'h00) || (b != 8'h00)};
      NotA:         r = {8'h00, (a == 8'h00)};
      Xor:          r = {1'b0, a ^ b};
      BitWise_And:  r = {1'b0, a & b};
      BitWise_Or:   r = {1'b0, a | b};
      BitWise_NotB: r = {1'b0, ~b};
      Shift_RightA: r = {a[0], 1'b0, a[7:1]};
      Shift_LeftB:  r = {b[7], b[6:0], 1'b0};
      IncrementA:   r = {1'b0, a} + 9'd1;
      DecrementB:   r = {(b == 8'h00), b - 8'd1};
      default:      r = 9'h000;
    endcase
    return r;
  endfunction

  function automatic rsp_t exp_of(input logic [7:0] a, input logic [7:0] b,
                                  input operation_e op, input logic [3:0] tag);
    rsp_t       e;
    logic [8:0] r;
    r       = alu_ref(a, b, op);
    e.out   = r[7:0];
    e.carry = r[8];
    e.tag   = tag;
    e.err   = 1'b0;
`ifdef ALU_DIVZERO_CHECK_EN
    if ((op == Div || op == Mod) && b == 8'h00) begin
      e.out   = 8'hFF;
      e.carry = 1'b0;
      e.err   = 1'b1;
    end
`endif
    return e;
  endfunction

  always_comb {bus.alu_carry, bus.alu_out} = alu_ref(bus.alu_a, bus.alu_b, bus.alu_opcode);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    logic prev_v;
    rsp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        if (!prev_v) rise_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp: got out=%h carry=%b tag=%h err=%b, required no response",
                   bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err);
        end else begin
          e = exp_q[0];
          if ({bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err} !== e) begin
            errors++;
            $display("FAIL rsp_data: got out=%h carry=%b tag=%h err=%b, required out=%h carry=%b tag=%h err=%b",
                     bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err,
                     e.out, e.carry, e.tag, e.err);
          end
        end
        if (bus.rsp_ready === 1'b1) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_cyc.push_back(cyc);
          n_rsp++;
          $display("rsp #%0d at cycle %0d: out=%h carry=%b tag=%h err=%b", n_rsp, cyc,
                   bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err);
        end
        prev_v = 1'b1;
      end else begin
        prev_v = 1'b0;
      end
    end
  end

  // Call just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input operation_e op,
                      input logic [3:0] tag, input int max_wait, output int acc);
    acc           = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
    for (int i = 0; i < max_wait; i++) begin
      @(negedge clk);
      if (bus.cmd_ready === 1'b1) begin
        acc = cyc + 1;
        exp_q.push_back(exp_of(a, b, op, tag));
        $display("cmd at cycle %0d: a=%h b=%h op=%s tag=%h", acc, a, b, op.name(), tag);
        break;
      end
      if (i < max_wait - 1) @(posedge clk);
    end
    if (acc < 0) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got cmd_ready=0 for %0d cycles, required 1", max_wait);
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input string name);
    int ok;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (n_rsp >= target) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d responses, required %0d", name, n_rsp, target);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int base;
    int tgt;
    logic [7:0] ra, rb;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_op    = Add;
    bus.cmd_tag   = '0;
    bus.rsp_ready = 1'b0;
    sent_done     = 1'b0;
    rst_n         = 1'b0;

    // ---- reset state
    step; step;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 0);
    chk("reset_alu", {bus.alu_a, bus.alu_b, 4'(bus.alu_opcode)}, 0);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err}, 0);
    step;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.cmd_ready), 1);
    step;

    // ---- single Add with latency check
    bus.rsp_ready = 1'b1;
    send(8'hF0, 8'h20, Add, 4'h3, 10, acc);
    wait_rsp(1, "single_add");
    chk("add_latency", 32'(rise_cyc - acc), 2);
    step; step;

    // ---- burst of 6 against a stalled consumer
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h10 * i + 8'h35), 8'(8'h13 + i), operation_e'(4'(i + 1)), 4'(i + 8), 10, acc);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_cmd_ready", 32'(bus.cmd_ready), 0);
      step;
    end
    base = hs_cyc.size();
    tgt  = n_rsp + 6;
    bus.rsp_ready = 1'b1;
    send(8'hA5, 8'h3C, Xor, 4'hD, 20, acc);
    wait_rsp(tgt, "burst");
    if (hs_cyc.size() >= base + 6) begin
      for (int j = 1; j < 6; j++) chk("burst_spacing", 32'(hs_cyc[base+j] - hs_cyc[base+j-1]), 2);
    end
    step;

    // ---- divide / modulo by zero and a normal divide
    tgt = n_rsp + 3;
    send(8'h07, 8'h00, Div, 4'h6, 10, acc);
    send(8'h09, 8'h00, Mod, 4'h7, 10, acc);
    send(8'h64, 8'h07, Div, 4'h8, 10, acc);
    wait_rsp(tgt, "divzero");
    step;

    // ---- IncrementA overflow with random consumer back-pressure
    bus.rsp_ready = 1'b0;
    tgt = n_rsp + 1;
    send(8'hFF, 8'h00, IncrementA, 4'h5, 10, acc);
    for (int i = 0; i < 60 && n_rsp < tgt; i++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      step;
    end
    bus.rsp_ready = 1'b1;
    wait_rsp(tgt, "inc_toggle");
    step;

    // ---- reset during ISSUE with two commands queued
    bus.rsp_ready = 1'b0;
    send(8'h11, 8'h01, Add, 4'h1, 10, acc);
    send(8'h5A, 8'h02, Sub, 4'h2, 10, acc);
    send(8'h33, 8'h03, Mul, 4'h3, 10, acc);
    send(8'h44, 8'h04, Xor, 4'h4, 10, acc);
    step;
    bus.rsp_ready = 1'b1;        // release the first response only
    step;                        // handshake edge: second command now in ISSUE
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("issue_alu_a", 32'(bus.alu_a), 32'h5A);
    chk("issue_rsp_valid", 32'(bus.rsp_valid), 0);
    step;                        // reset edge
    exp_q.delete();
    base = n_rsp;
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("midreset_alu", {bus.alu_a, bus.alu_b, 4'(bus.alu_opcode)}, 0);
    chk("midreset_rsp", {bus.rsp_valid, bus.rsp_out, bus.rsp_carry, bus.rsp_tag, bus.rsp_err}, 0);
    chk("midreset_cmd_ready", 32'(bus.cmd_ready), 1);
    repeat (10) step;
    chk("midreset_no_rsp", 32'(n_rsp - base), 0);

    // ---- randomized traffic
    tgt = n_rsp + 40;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          ra = 8'($urandom_range(0, 255));
          rb = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
          send(ra, rb, operation_e'(4'($urandom_range(0, 15))), 4'($urandom_range(0, 15)), 50, acc);
          repeat ($urandom_range(0, 2)) step;
        end
        sent_done = 1'b1;
      end
      begin
        for (int i = 0; i < 3000; i++) begin
          bus.rsp_ready = ($urandom_range(0, 3) != 0);
          step;
          if (sent_done && exp_q.size() == 0) break;
        end
      end
    join
    chk("random_drain_count", 32'(n_rsp), 32'(tgt));
    chk("random_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
